// File: rtl/dp_bus_loader_pkg.sv
// Shared definitions for the dot-product operand bus: loader state encoding,
// slot-count derivation and the ceil-log2 helper also used by the dot-product unit.
package dp_bus_loader_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Total slot count across all consumer lanes; slot k sits in lane k/bus_width.
    function automatic int total_slots(input int parallel, input int bus_width);
        return parallel * bus_width;
    endfunction

endpackage

// File: rtl/dp_bus_loader.sv
// Packs serial pixel/weight pairs into the flat Pixels/Weights buses, hands the
// filled buses to the dot-product unit with a start pulse and waits for its ack.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_FILL | accepting pairs, writing slot[fill_count], buses not valid
// ST_HOLD | buses frozen and valid, dp_start on first cycle, wait bus_ack
module dp_bus_loader
    import dp_bus_loader_pkg::*;
#(
    parameter int PARALLEL    = 1,
    parameter int BUS_WIDTH   = 196,
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int CNT_W       = 16,
    localparam int TOTAL      = total_slots(PARALLEL, BUS_WIDTH),
    localparam int FC_W       = clog2(TOTAL) + 1
) (
    input  logic                           clk,
    input  logic                           GlobalReset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [PIXEL_SIZE-1:0]          in_pixel,
    input  logic [WEIGHT_SIZE-1:0]         in_weight,
    input  logic                           in_last,
    output logic [TOTAL*PIXEL_SIZE-1:0]    Pixels,
    output logic [TOTAL*WEIGHT_SIZE-1:0]   Weights,
    output logic                           bus_valid,
    output logic                           dp_start,
    input  logic                           bus_ack,
    output logic [FC_W-1:0]                fill_count,
    output logic [CNT_W-1:0]               vec_count
);

    state_t             r_state;
    logic [FC_W-1:0]    r_fill_count;
    logic [CNT_W-1:0]   r_vec_count;
    logic               r_dp_start;
    logic               r_bus_valid;

    logic               w_accept;
    logic               w_final;
    logic               w_clear;

    assign w_accept = in_valid && (r_state == ST_FILL);
    // The last slot closes the vector even without in_last, so overflow cannot occur.
    assign w_final  = w_accept && (in_last || (r_fill_count == FC_W'(TOTAL - 1)));
    assign w_clear  = (r_state == ST_HOLD) && bus_ack;

    // Clearing on ack keeps unwritten slots at zero, so short vectors are zero-padded.
    for (genvar k = 0; k < TOTAL; k++) begin : g_slot
        logic                   w_we;
        logic [PIXEL_SIZE-1:0]  r_pixel;
        logic [WEIGHT_SIZE-1:0] r_weight;

        assign w_we = w_accept && (r_fill_count == FC_W'(k));

        always_ff @(posedge clk or posedge GlobalReset) begin
            if (GlobalReset) begin
                r_pixel  <= '0;
                r_weight <= '0;
            end else if (w_clear) begin
                r_pixel  <= '0;
                r_weight <= '0;
            end else if (w_we) begin
                r_pixel  <= in_pixel;
                r_weight <= in_weight;
            end
        end

        assign Pixels[k*PIXEL_SIZE +: PIXEL_SIZE]    = r_pixel;
        assign Weights[k*WEIGHT_SIZE +: WEIGHT_SIZE] = r_weight;
    end

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            r_state      <= ST_FILL;
            r_fill_count <= '0;
            r_vec_count  <= '0;
            r_dp_start   <= 1'b0;
            r_bus_valid  <= 1'b0;
        end else begin
            r_dp_start <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        r_fill_count <= r_fill_count + FC_W'(1);
                    end
                    if (w_final) begin
                        r_state     <= ST_HOLD;
                        r_dp_start  <= 1'b1;
                        r_bus_valid <= 1'b1;
                        r_vec_count <= r_vec_count + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus_ack) begin
                        r_state      <= ST_FILL;
                        r_fill_count <= '0;
                        r_bus_valid  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == ST_FILL);
    assign bus_valid  = r_bus_valid;
    assign dp_start   = r_dp_start;
    assign fill_count = r_fill_count;
    assign vec_count  = r_vec_count;

endmodule
